// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT butterfly sequencer.
package ntt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [2:0] OP_BFLY  = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam int         PIPE_LAT = 2;
endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational Cooley-Tukey butterfly address / twiddle index generator.
module ntt_addr_gen #(
  parameter int LOG_N = 3,
  parameter int SW    = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
  input  logic [SW-1:0]    stage,
  input  logic [LOG_N-2:0] j,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-2:0] tw_addr
);
  logic [LOG_N-1:0] j_ext, half, k;

  always_comb begin
    j_ext   = {1'b0, j};
    half    = LOG_N'(1) << stage;
    k       = j_ext & (half - LOG_N'(1));
    // group base = (j >> s) * 2^(s+1); shifted in two steps so s+1 never overflows SW bits
    addr_a  = (((j_ext >> stage) << stage) << 1) | k;
    addr_b  = addr_a + half;
    tw_addr = (LOG_N-1)'(k << (LOG_N - 1 - stage));
  end
endmodule

// File: rtl/ntt_bf_sequencer.sv
// In-place radix-2 NTT sequencer feeding ntt_arith_unit and writing results back.
// Optional NTT_CYCLE_CNT_EN adds a saturating busy-cycle counter output.
module ntt_bf_sequencer
  import ntt_pkg::*;
#(
  parameter int LOG_N  = 3,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] q_in,
  input  logic [DATA_W-1:0] mu_in,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [LOG_N-1:0]  rd_addr_a,
  output logic [LOG_N-1:0]  rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic [LOG_N-2:0]  tw_addr,
  input  logic [DATA_W-1:0] tw_data,
  output logic [2:0]        au_opcode,
  output logic [DATA_W-1:0] au_op_a,
  output logic [DATA_W-1:0] au_op_b,
  output logic [DATA_W-1:0] au_op_w,
  output logic [DATA_W-1:0] au_op_q,
  output logic [DATA_W-1:0] au_op_mu,
  input  logic [DATA_W-1:0] au_res_1,
  input  logic [DATA_W-1:0] au_res_2,
  output logic              wr_en,
  output logic [LOG_N-1:0]  wr_addr_a,
  output logic [LOG_N-1:0]  wr_addr_b,
  output logic [DATA_W-1:0] wr_data_a,
  output logic [DATA_W-1:0] wr_data_b
`ifdef NTT_CYCLE_CNT_EN
  , output logic [15:0]     cycle_cnt
`endif
);
  localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG_N - 1);

  state_t               state, next;
  logic [SW-1:0]        stage;
  logic [LOG_N-2:0]     j;
  logic                 drain_cnt;
  logic [DATA_W-1:0]    q_lat, mu_lat;
  logic [LOG_N-1:0]     ag_a, ag_b;
  logic [LOG_N-2:0]     ag_tw;
  logic [PIPE_LAT:1]    vld_pipe;
  logic [PIPE_LAT:1][LOG_N-1:0] wa_pipe, wb_pipe;

  ntt_addr_gen #(.LOG_N(LOG_N), .SW(SW)) u_addr_gen (
    .stage  (stage),
    .j      (j),
    .addr_a (ag_a),
    .addr_b (ag_b),
    .tw_addr(ag_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next      = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    au_opcode = OP_ADD;
    case (state)
      IDLE:  if (start) next = RUN;
      RUN: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        au_opcode = OP_BFLY;
        if (j == '1) next = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        au_opcode = OP_BFLY;
        if (drain_cnt) next = (stage == LAST_STAGE) ? DONE : RUN;
      end
      DONE:    begin done = 1'b1; next = IDLE; end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage     <= '0;
      j         <= '0;
      drain_cnt <= 1'b0;
      q_lat     <= '0;
      mu_lat    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          q_lat  <= q_in;
          mu_lat <= mu_in;
          stage  <= '0;
          j      <= '0;
        end
        RUN: begin
          j         <= j + 1'b1;   // wraps to 0 on the last butterfly
          drain_cnt <= 1'b0;
        end
        DRAIN: begin
          drain_cnt <= ~drain_cnt;
          if (drain_cnt) stage <= (stage == LAST_STAGE) ? '0 : stage + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_addr_a = rd_en ? ag_a  : '0;
  assign rd_addr_b = rd_en ? ag_b  : '0;
  assign tw_addr   = rd_en ? ag_tw : '0;

  // Issue addresses ride alongside the read/arith latency to become write addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      wa_pipe  <= '0;
      wb_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_LAT-1:1], rd_en};
      wa_pipe  <= {wa_pipe[PIPE_LAT-1:1], rd_addr_a};
      wb_pipe  <= {wb_pipe[PIPE_LAT-1:1], rd_addr_b};
    end
  end

  assign wr_en     = vld_pipe[PIPE_LAT];
  assign wr_addr_a = wa_pipe[PIPE_LAT];
  assign wr_addr_b = wb_pipe[PIPE_LAT];
  assign wr_data_a = au_res_1;
  assign wr_data_b = au_res_2;

  assign au_op_a  = rd_data_a;
  assign au_op_b  = rd_data_b;
  assign au_op_w  = tw_data;
  assign au_op_q  = q_lat;
  assign au_op_mu = mu_lat;

`ifdef NTT_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                              cycle_cnt <= '0;
    else if (state == IDLE && start)      cycle_cnt <= '0;
    else if (busy && cycle_cnt != '1)     cycle_cnt <= cycle_cnt + 16'd1;
  end
`endif
endmodule
